icache_sa: RTL and testbench
============================

# icache_sa

Parametrised set-associative instruction cache between the fetch stage and the instruction memory bus. It generalises the earlier 2-way, 256-set, 8-word-line, 4-wide fetch cache in four ways: configurable ways, sets, line size and fetch width; tree-PLRU replacement; offset-correct alignment of refill data; and a whole-cache flush. Lookups hit in one cycle. A miss issues one line-aligned burst request and answers the fetch directly from the returned line.

## Interface
- WAYS, 2, associativity; 2 or 4
- SETS, 256, sets per way; power of two
- LINE_WORDS, 8, 32-bit words per line; power of two, at least FETCH_WIDTH
- FETCH_WIDTH, 4, instruction slots per response
- clk  in  1  clock; everything is on the rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request
- req_pc  in  32  fetch address; bits [1:0] ignored
- req_ready  out  1  request accepted this cycle when high together with req_valid
- flush  in  1  single-cycle pulse; invalidates every line
- resp_valid  out  1  single-cycle response pulse; no backpressure
- resp_inst  out  33*FETCH_WIDTH  slot i occupies [33i+32:33i] as {valid, inst}; slot 0 is the instruction at req_pc
- mem_req  out  1  line read request
- mem_addr  out  32  line-aligned address (offset bits zero)
- mem_addr_ok  in  1  slave accepted the address
- mem_data_ok  in  1  full line present on mem_rdata
- mem_rdata  in  32*LINE_WORDS  word w at [32w+31:32w]

## Operation
Address fields:
- OFF = log2(LINE_WORDS)+2
- IDX = log2(SETS)
- TAG = 32-IDX-OFF
- word offset wo = pc[OFF-1:2]

Storage is flop arrays: valid[WAYS][SETS], tag[WAYS][SETS], data[WAYS][SETS], plru[SETS][WAYS-1].

State machine:
- IDLE
  - req_ready=1.
  - Accepting a request registers the pc, then go to LOOKUP.
- LOOKUP
  - Compare tags for the registered pc across all ways.
  - Hit: resp_valid=1 and the PLRU bits for the set are updated toward the hit way. req_ready=1, so a new request may be accepted in the same cycle; go to LOOKUP if one is accepted, else IDLE.
  - Miss: latch the victim way and go to MISS. The victim is the lowest-index invalid way; if all ways are valid, the PLRU victim.
- MISS
  - mem_req=1 and mem_addr={tag,idx,OFF'b0} are held until mem_addr_ok, then go to REFILL.
- REFILL
  - Wait for mem_data_ok.
  - On mem_data_ok: write the line, tag and valid=1 into the victim way, update PLRU toward the victim, and raise resp_valid from mem_rdata aligned by wo. Go to IDLE.
- req_ready=0 in MISS and REFILL.

Alignment: slot i is valid and holds word wo+i when wo+i < LINE_WORDS. Otherwise slot i is all zero. A fetch never crosses a line boundary.

Flush:
- Clears all valid bits at the clock edge where it is sampled.
- When sampled in MISS or REFILL, a drop flag is set. The refill still completes and responds, but the line is not installed.
- Flush together with a hit in LOOKUP: the response is still given and the valid bits are cleared.

Reset takes effect in any state:
- state=IDLE; all valid bits, PLRU bits and the drop flag are cleared.
- Outputs: req_ready=1, resp_valid=0, resp_inst=0, mem_req=0, mem_addr=0.
- mem_data_ok arriving after a reset is ignored, because the cache is in IDLE.

## Timing
- Hit latency: request accepted at cycle t gives resp_valid at t+1. A request every cycle gets a hit response every cycle.
- Miss latency: accept at t, LOOKUP at t+1, mem_req from t+2, response in the mem_data_ok cycle.
- mem_addr is stable while mem_req is high.
- mem_data_ok is only honoured in REFILL.
- Tag arrays are written only in the REFILL completion cycle and read combinationally in LOOKUP, so a hit on a just-refilled line is visible one cycle later.

## Configuration
- ICACHE_PERF_EN defined:
  - Adds output ports perf_hit  out  32 and perf_miss  out  32.
  - perf_hit increments on each LOOKUP hit and perf_miss on each LOOKUP miss.
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: neither the ports nor the counters exist.

## Structure
- Package icache_pkg:
  - state enum (IDLE, LOOKUP, MISS, REFILL)
  - field-width localparam functions (OFF, IDX, TAG from the parameters)
  - PLRU next-state and victim functions for WAYS 2 and 4
- Sub-module icache_align: combinational extraction of FETCH_WIDTH slots from one line given wo. It is used for both hit data and refill data.

## Test plan
Defaults are used throughout; W0..W7 are the refill words.
- Cold miss: req_pc=0x0000_1000 → mem_req with mem_addr=0x1000. Return W0..W7 → resp slots {1,W0}..{1,W3}. Re-request 0x1000 → resp_valid one cycle after acceptance, with no mem_req.
- Line tail: after the fill above, req_pc=0x1014 → slots 0-2 = W5,W6,W7 valid; slot 3 = 33'd0.
- Replacement: fill 0x1000 and 0x3000 (both index 0x80), hit 0x1000, then miss 0x5000 → 0x3000 is evicted. 0x1000 then hits and 0x3000 misses.
- Back-to-back: after filling 0x1000, requests 0x1000, 0x1004, 0x1008 on consecutive cycles → three consecutive resp_valid, with req_ready held high.
- Flush in REFILL: flush while waiting for the 0x2000 refill → the response is still delivered; a following fetch of 0x2000 issues mem_req again.
- Reset mid-REFILL: resetn low during REFILL → state IDLE, mem_req=0, resp_valid=0; a late mem_data_ok produces no response. With ICACHE_PERF_EN, perf_hit and perf_miss read 0.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and helpers for the set-associative instruction cache.
// Holds the controller state encoding, address field-width helpers and the
// tree-PLRU update/victim functions used for 2-way and 4-way configurations.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MISS   = 2'd2,
        ST_REFILL = 2'd3
    } state_e;

    // Byte-offset field width: word offset bits plus the two byte bits.
    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    // Set index field width.
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag field width: whatever remains of the 32-bit address.
    function automatic int tag_w(input int sets, input int line_words);
        return 32 - idx_w(sets) - off_w(line_words);
    endfunction

    // Tree-PLRU update: make 'way' most recently used.
    // Each node bit points at the subtree holding the next victim.
    // 2-way uses bit 0 only; 4-way uses bit 0 as the root, bit 1 for
    // ways 0/1 and bit 2 for ways 2/3.
    function automatic logic [2:0] plru_touch(input int ways,
                                              input logic [2:0] bits,
                                              input logic [1:0] way);
        logic [2:0] nxt;
        nxt = bits;
        if (ways == 2) begin
            nxt[0] = ~way[0];
        end else if (!way[1]) begin
            nxt[0] = 1'b1;
            nxt[1] = ~way[0];
        end else begin
            nxt[0] = 1'b0;
            nxt[2] = ~way[0];
        end
        return nxt;
    endfunction

    // Tree-PLRU victim: follow the node bits from the root.
    function automatic logic [1:0] plru_victim(input int ways,
                                               input logic [2:0] bits);
        logic [1:0] v;
        if (ways == 2) begin
            v = {1'b0, bits[0]};
        end else if (!bits[0]) begin
            v = {1'b0, bits[1]};
        end else begin
            v = {1'b1, bits[2]};
        end
        return v;
    endfunction

endpackage

// File: rtl/icache_align.sv
// icache_align: picks FETCH_WIDTH consecutive words out of one cache line,
// starting at word offset wo. Slots that would run past the end of the line
// are returned as all zero (valid bit clear); a fetch never wraps into the
// next line. Shared by the hit path and the refill path.
module icache_align #(
    parameter int LINE_WORDS  = 8,
    parameter int FETCH_WIDTH = 4
) (
    input  logic [32*LINE_WORDS-1:0]    line,
    input  logic [$clog2(LINE_WORDS)-1:0] wo,
    output logic [33*FETCH_WIDTH-1:0]   slots
);

    // Slot i carries {1, word wo+i} while wo+i stays inside the line.
    always_comb begin
        slots = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (int'(wo) + i < LINE_WORDS) begin
                slots[33*i +: 33] = {1'b1, line[32*(int'(wo) + i) +: 32]};
            end
        end
    end

endmodule

// File: rtl/icache_sa.sv
// icache_sa: parametrised set-associative instruction cache with tree-PLRU
// replacement, one-cycle hits, single-burst line refill answered straight from
// the returned line, and a whole-cache flush.
// Optional feature: define ICACHE_PERF_EN to add perf_hit/perf_miss counters.
module icache_sa
    import icache_pkg::*;
#(
    parameter int WAYS        = 2,
    parameter int SETS        = 256,
    parameter int LINE_WORDS  = 8,
    parameter int FETCH_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req_valid,
    input  logic [31:0]               req_pc,
    output logic                      req_ready,
    input  logic                      flush,
    output logic                      resp_valid,
    output logic [33*FETCH_WIDTH-1:0] resp_inst,
    output logic                      mem_req,
    output logic [31:0]               mem_addr,
    input  logic                      mem_addr_ok,
    input  logic                      mem_data_ok,
    input  logic [32*LINE_WORDS-1:0]  mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]               perf_hit,
    output logic [31:0]               perf_miss
`endif
);

    localparam int OFF    = off_w(LINE_WORDS);
    localparam int IDX    = idx_w(SETS);
    localparam int TAG    = tag_w(SETS, LINE_WORDS);
    localparam int WO_W   = OFF - 2;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PLRU_W = WAYS - 1;
    localparam int LINE_W = 32 * LINE_WORDS;

    state_e                 state_q;
    state_e                 state_d;

    // Registered fetch address (word granularity) for the request in flight.
    logic [31:2]            pc_p1;

    logic [SETS-1:0]        valid_q [WAYS];
    logic [TAG-1:0]         tag_q   [WAYS][SETS];
    logic [LINE_W-1:0]      data_q  [WAYS][SETS];
    logic [PLRU_W-1:0]      plru_q  [SETS];

    logic [WAY_W-1:0]       victim_q;
    logic                   drop_q;

    logic [TAG-1:0]         cur_tag;
    logic [IDX-1:0]         cur_idx;
    logic [WO_W-1:0]        cur_wo;

    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic [WAY_W-1:0]       victim;
    logic                   lookup_hit;
    logic                   lookup_miss;
    logic                   refill_done;
    logic                   install;
    logic                   accept;
    logic [LINE_W-1:0]      align_line;
    logic [33*FETCH_WIDTH-1:0] slots;

    // The two byte-select bits of the fetch address carry no information.
    logic                   unused_pc_lo;
    assign unused_pc_lo = ^req_pc[1:0];

    assign cur_tag = pc_p1[31:OFF+IDX];
    assign cur_idx = pc_p1[OFF+IDX-1:OFF];
    assign cur_wo  = pc_p1[OFF-1:2];

    // Tag compare across all ways for the registered address.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[w][cur_idx] && (tag_q[w][cur_idx] == cur_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest invalid way first, otherwise the PLRU pick.
    always_comb begin
        logic found;
        found  = 1'b0;
        victim = WAY_W'(plru_victim(WAYS, 3'(plru_q[cur_idx])));
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[w][cur_idx]) begin
                found  = 1'b1;
                victim = WAY_W'(w);
            end
        end
    end

    assign lookup_hit  = (state_q == ST_LOOKUP) && hit;
    assign lookup_miss = (state_q == ST_LOOKUP) && !hit;
    assign refill_done = (state_q == ST_REFILL) && mem_data_ok;
    // A flush seen during the miss, or in the completion cycle itself, keeps
    // the returned line out of the arrays while still answering the fetch.
    assign install     = refill_done && !drop_q && !flush;

    assign req_ready   = (state_q == ST_IDLE) || lookup_hit;
    assign accept      = req_valid && req_ready;

    assign align_line  = (state_q == ST_REFILL) ? mem_rdata : data_q[hit_way][cur_idx];

    icache_align #(
        .LINE_WORDS  (LINE_WORDS),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_align (
        .line  (align_line),
        .wo    (cur_wo),
        .slots (slots)
    );

    assign resp_valid = lookup_hit || refill_done;
    assign resp_inst  = resp_valid ? slots : '0;
    assign mem_req    = (state_q == ST_MISS);
    assign mem_addr   = mem_req ? {pc_p1[31:OFF], {OFF{1'b0}}} : 32'd0;

    // Controller next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (!hit)           state_d = ST_MISS;
                else if (req_valid) state_d = ST_LOOKUP;
                else                state_d = ST_IDLE;
            end
            ST_MISS:   if (mem_addr_ok) state_d = ST_REFILL;
            ST_REFILL: if (mem_data_ok) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Controller state and the flush drop flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (refill_done) begin
                drop_q <= 1'b0;
            end else if (flush && ((state_q == ST_MISS) || (state_q == ST_REFILL))) begin
                drop_q <= 1'b1;
            end
        end
    end

    // --- request capture and victim latch (no reset: pure data) ---
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_p1 <= req_pc[31:2];
        end
        if (lookup_miss) begin
            victim_q <= victim;
        end
    end

    // Valid bits: cleared by reset or flush, set when a refill installs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else if (flush) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else if (install) begin
            valid_q[victim_q][cur_idx] <= 1'b1;
        end
    end

    // PLRU bits move toward the hit way, or toward the refilled way.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else if (lookup_hit) begin
            plru_q[cur_idx] <= PLRU_W'(plru_touch(WAYS, 3'(plru_q[cur_idx]), 2'(hit_way)));
        end else if (refill_done) begin
            plru_q[cur_idx] <= PLRU_W'(plru_touch(WAYS, 3'(plru_q[cur_idx]), 2'(victim_q)));
        end
    end

    // Tag and line storage, written only in the refill completion cycle.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[victim_q][cur_idx]  <= cur_tag;
            data_q[victim_q][cur_idx] <= mem_rdata;
        end
    end

`ifdef ICACHE_PERF_EN
    // Hit/miss event counters, one event per LOOKUP cycle, wrapping at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_hit  <= 32'd0;
            perf_miss <= 32'd0;
        end else begin
            if (lookup_hit) begin
                perf_hit <= perf_hit + 32'd1;
            end
            if (lookup_miss) begin
                perf_miss <= perf_miss + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: self-checking bench for icache_sa (default parameters).
// A behavioural model tracks which lines each set holds and which way was
// used last; memory contents are a fixed function of the word address.
module tb_icache_sa;

    localparam int WAYS = 2;
    localparam int SETS = 256;
    localparam int LW   = 8;
    localparam int FW   = 4;

    logic              clk;
    logic              resetn;
    logic              req_valid;
    logic [31:0]       req_pc;
    logic              req_ready;
    logic              flush;
    logic              resp_valid;
    logic [33*FW-1:0]  resp_inst;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [32*LW-1:0]  mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0]       perf_hit;
    logic [31:0]       perf_miss;
`endif

    icache_sa #(
        .WAYS        (WAYS),
        .SETS        (SETS),
        .LINE_WORDS  (LW),
        .FETCH_WIDTH (FW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .req_ready   (req_ready),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_inst   (resp_inst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit    (perf_hit),
        .perf_miss   (perf_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_valid [WAYS][SETS];
    logic [18:0] m_tag   [WAYS][SETS];
    int          m_last  [SETS];
    int          m_hits;
    int          m_misses;

    task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [32*LW-1:0] line_data(input logic [31:0] pc);
        logic [32*LW-1:0] d;
        logic [31:0] base;
        base = {pc[31:5], 5'b0};
        for (int w = 0; w < LW; w++) d[32*w +: 32] = mem_word(base + 32'(4*w));
        return d;
    endfunction

    // Expected fetch bundle: words from pc onward, stopping at the line end.
    function automatic logic [33*FW-1:0] exp_resp(input logic [31:0] pc);
        logic [33*FW-1:0] r;
        logic [31:0] base;
        int wo;
        r = '0;
        base = {pc[31:5], 5'b0};
        wo = int'(pc[4:2]);
        for (int i = 0; i < FW; i++) begin
            if (wo + i < LW) r[33*i +: 33] = {1'b1, mem_word(base + 32'(4*(wo + i)))};
        end
        return r;
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        int s;
        s = int'(pc[12:5]);
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[w][s] && m_tag[w][s] == pc[31:13]) return w;
        end
        return -1;
    endfunction

    // With two ways the least recently used one is simply the other one.
    function automatic int m_victim(input int s);
        for (int w = 0; w < WAYS; w++) if (!m_valid[w][s]) return w;
        return 1 - m_last[s];
    endfunction

    task automatic m_flush();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk); #1;
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
        m_flush();
    endtask

    // One complete fetch: accept, lookup, and on a miss serve the refill.
    task automatic fetch(input logic [31:0] pc, input bit flush_refill, output bit was_hit);
        int s, way, victim, d;
        bit dropped;
        logic [33*FW-1:0] er;
        s = int'(pc[12:5]);
        er = exp_resp(pc);
        dropped = 1'b0;
        @(negedge clk); #1;
        check("idle_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_pc = pc;
        @(negedge clk); #1;
        req_valid = 1'b0;
        way = m_find(pc);
        was_hit = resp_valid;
        check("lookup_hit", resp_valid, way >= 0);
        if (way >= 0) begin
            check("hit_data", resp_inst, er);
            check("hit_no_mem_req", mem_req, 1'b0);
            m_last[s] = way;
            m_hits++;
        end else begin
            m_misses++;
            victim = m_victim(s);
            check("miss_not_ready", req_ready, 1'b0);
            d = int'($urandom_range(0, 3));
            @(negedge clk); #1;
            check("mem_req", mem_req, 1'b1);
            check("mem_addr", mem_addr, {pc[31:5], 5'b0});
            for (int k = 0; k < d; k++) begin
                @(negedge clk); #1;
                check("mem_req_held", mem_req, 1'b1);
                check("mem_addr_held", mem_addr, {pc[31:5], 5'b0});
            end
            mem_addr_ok = 1'b1;
            @(negedge clk); #1;
            mem_addr_ok = 1'b0;
            check("refill_no_mem_req", mem_req, 1'b0);
            check("refill_not_ready", req_ready, 1'b0);
            d = flush_refill ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            for (int k = 0; k < d; k++) begin
                check("refill_wait_quiet", resp_valid, 1'b0);
                if (flush_refill && k == 0) flush = 1'b1;
                @(negedge clk); #1;
                flush = 1'b0;
            end
            if (flush_refill) begin
                m_flush();
                dropped = 1'b1;
            end
            mem_rdata = line_data(pc);
            mem_data_ok = 1'b1;
            #1;
            check("refill_resp_valid", resp_valid, 1'b1);
            check("refill_data", resp_inst, er);
            @(negedge clk); #1;
            mem_data_ok = 1'b0;
            mem_rdata = '0;
            check("after_refill_ready", req_ready, 1'b1);
            if (!dropped) begin
                m_valid[victim][s] = 1'b1;
                m_tag[victim][s] = pc[31:13];
            end
            m_last[s] = victim;
        end
    endtask

    bit h;
    int way;
    logic [31:0] pcs [3];
    logic [31:0] pc;

    initial begin
        resetn = 1'b0;
        req_valid = 1'b0;
        req_pc = '0;
        flush = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata = '0;
        m_hits = 0;
        m_misses = 0;
        m_flush();
        for (int s = 0; s < SETS; s++) m_last[s] = 0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_inst", resp_inst, '0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        resetn = 1'b1;

        // Cold miss, refetch hit, line tail.
        fetch(32'h0000_1000, 1'b0, h); check("cold_miss", h, 1'b0);
        fetch(32'h0000_1000, 1'b0, h); check("refetch_hit", h, 1'b1);
        fetch(32'h0000_1014, 1'b0, h); check("tail_hit", h, 1'b1);

        // Replacement within index 0x80.
        fetch(32'h0000_3000, 1'b0, h); check("fill_3000", h, 1'b0);
        fetch(32'h0000_1000, 1'b0, h); check("hit_1000", h, 1'b1);
        fetch(32'h0000_5000, 1'b0, h); check("miss_5000", h, 1'b0);
        fetch(32'h0000_1000, 1'b0, h); check("kept_1000", h, 1'b1);
        fetch(32'h0000_3000, 1'b0, h); check("evicted_3000", h, 1'b0);

        // Back-to-back hits.
        pcs[0] = 32'h0000_1000; pcs[1] = 32'h0000_1004; pcs[2] = 32'h0000_1008;
        @(negedge clk); #1;
        check("b2b_ready0", req_ready, 1'b1);
        req_valid = 1'b1;
        req_pc = pcs[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            way = m_find(pcs[i]);
            check("b2b_resp_valid", resp_valid, 1'b1);
            check("b2b_data", resp_inst, exp_resp(pcs[i]));
            check("b2b_ready", req_ready, 1'b1);
            if (way >= 0) m_last[int'(pcs[i][12:5])] = way;
            m_hits++;
            if (i < 2) req_pc = pcs[i+1];
            else req_valid = 1'b0;
        end
        @(negedge clk); #1;
        check("b2b_end_quiet", resp_valid, 1'b0);

        // Flush during refill: response delivered, line not kept.
        fetch(32'h0000_2000, 1'b1, h); check("flush_refill_miss", h, 1'b0);
        fetch(32'h0000_2000, 1'b0, h); check("refetch_after_drop", h, 1'b0);

        // Randomized traffic over two sets and four tags.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) do_flush();
            pc = (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(8'h80, 8'h81)) << 5) |
                 (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            fetch(pc, ($urandom_range(0, 7) == 0), h);
        end

`ifdef ICACHE_PERF_EN
        check("perf_hit", perf_hit, 32'(m_hits));
        check("perf_miss", perf_miss, 32'(m_misses));
`endif

        // Reset in the middle of a refill.
        do_flush();
        @(negedge clk); #1;
        req_valid = 1'b1;
        req_pc = 32'h0000_7000;
        @(negedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        mem_addr_ok = 1'b1;
        @(negedge clk); #1;
        mem_addr_ok = 1'b0;
        check("pre_rst_refill", req_ready, 1'b0);
        resetn = 1'b0;
        #1;
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_resp_valid", resp_valid, 1'b0);
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_mem_addr", mem_addr, 32'd0);
`ifdef ICACHE_PERF_EN
        check("midrst_perf_hit", perf_hit, 32'd0);
        check("midrst_perf_miss", perf_miss, 32'd0);
`endif
        m_flush();
        m_hits = 0;
        m_misses = 0;
        @(negedge clk); #1;
        resetn = 1'b1;
        mem_rdata = line_data(32'h0000_7000);
        mem_data_ok = 1'b1;
        #1;
        check("late_data_ignored", resp_valid, 1'b0);
        @(negedge clk); #1;
        mem_data_ok = 1'b0;
        mem_rdata = '0;
        check("late_data_idle", req_ready, 1'b1);

        fetch(32'h0000_7000, 1'b0, h); check("post_rst_miss", h, 1'b0);
        fetch(32'h0000_7000, 1'b0, h); check("post_rst_hit", h, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
